imem_port_arbiter: RTL

//  Shares one single-ported unified memory between the instruction fetch stage and the

---
 rtl/imem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// mem_rdata is expected MEM_LAT cycles after mem_en, counting the mem_en cycle as the first.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  owner_t     owner;
  logic       store_q;
  logic       flush_pend;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;

  logic if_wins;
  logic enter_resp;
  logic flush_hit;

  // Fetch takes the port when load/store is idle or has used up its starvation budget.
  assign if_wins    = if_req && (!ls_req || (starve_cnt == STARVE_LIM));
  assign enter_resp = ((state == ISSUE) && (MEM_LAT == 1)) ||
                      ((state == WAIT) && (lat_cnt == 4'd1));
  assign flush_hit  = if_flush && (owner == OWN_IF) && (state != IDLE);

  // NOTE: async reset clears every register here; all state is plain flops, no memory arrays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      store_q    <= 1'b0;
      flush_pend <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_gnt     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so every branch sees this cycle's values, not updated ones.
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (flush_hit) flush_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          owner      <= OWN_NONE;
          flush_pend <= 1'b0;
          if (if_req || ls_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (if_wins) begin
              owner      <= OWN_IF;
              if_gnt     <= 1'b1;
              store_q    <= 1'b0;
              mem_we     <= 1'b0;
              mem_be     <= '1;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              owner     <= OWN_LS;
              ls_gnt    <= 1'b1;
              store_q   <= ls_we;
              mem_we    <= ls_we;
              mem_be    <= ls_we ? ls_be : '1;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              if (if_req && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= (MEM_LAT == 1) ? RESP : WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          flush_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A flush seen up to the capture edge (including this cycle) suppresses the response.
      if (enter_resp) begin
        if (owner == OWN_IF) begin
          if_rvalid <= !(flush_pend || flush_hit);
          if_rdata  <= mem_rdata;
        end else begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= store_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
